// File: rtl/fpaddsub_pkg.sv
// Shared codes and constants for the FP32 add/sub rounding stage.
package fpaddsub_pkg;

  localparam logic [1:0] EXC_NORMAL = 2'b00;
  localparam logic [1:0] EXC_ZERO   = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX   = 8'hFF;

  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  // Field order matches the Flags port: {invalid, overflow, underflow, inexact}.
  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

endpackage

// File: rtl/fpaddsub_pack.sv
// Purpose: stage-2 exception priority, exponent carry and IEEE-754 packing.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline register decides when to capture.
module fpaddsub_pack
  import fpaddsub_pkg::*;
#(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
) (
  input  logic                    sign,
  input  logic [1:0]              exc,
  input  logic                    neg_e,
  input  logic                    zero_sum,
  input  logic [EXP_W:0]          norm_e,
  input  logic [MANT_W:0]         mant_r,
  input  logic                    inexact,
  output logic [EXP_W+MANT_W:0]   result,
  output flags_t                  flags
);

  logic                carry;
  logic [EXP_W+1:0]    exp_ext;
  logic [MANT_W-1:0]   mant;

  // One extra exponent bit so NormE at its maximum plus a rounding carry cannot wrap.
  assign carry   = mant_r[MANT_W];
  assign exp_ext = {1'b0, norm_e} + (EXP_W+2)'(carry);
  assign mant    = carry ? '0 : mant_r[MANT_W-1:0];

  always_comb begin
    result        = {sign, exp_ext[EXP_W-1:0], mant};
    flags         = '0;
    flags.inexact = inexact;
    if (exc == EXC_NAN) begin
      result        = FP32_QNAN;
      flags         = '0;
      flags.invalid = 1'b1;
    end else if (exc == EXC_INF) begin
      result = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      flags  = '0;
    end else if (exc == EXC_ZERO || zero_sum) begin
      result = {sign, {(EXP_W+MANT_W){1'b0}}};
      flags  = '0;
    end else if (neg_e || exp_ext == '0) begin
      result          = {sign, {(EXP_W+MANT_W){1'b0}}};
      flags.underflow = 1'b1;
      flags.inexact   = 1'b1;
    end else if (exp_ext >= {2'b00, {EXP_W{1'b1}}}) begin
      result         = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      flags.overflow = 1'b1;
      flags.inexact  = 1'b1;
    end
  end

endmodule

// File: rtl/fpaddsub_round_pipe.sv
// Purpose: round-to-nearest-even and pack FP32 add/sub result; FPADDSUB_STICKY_FLAGS_EN adds FlagsAcc.
// Latency: 2 cycles in-transfer to out_valid, one result per cycle when out_ready stays high.
// Backpressure: in_ready = !v1 | !v2 | out_ready, combinational, no skid buffer.
module fpaddsub_round_pipe
  import fpaddsub_pkg::*;
#(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef FPADDSUB_STICKY_FLAGS_EN
  input  logic                   flag_clr,
  output logic [3:0]             FlagsAcc,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MANT_W-1:0]      NormM,
  input  logic [EXP_W:0]         NormE,
  input  logic                   NegE,
  input  logic                   ZeroSum,
  input  logic                   FG,
  input  logic                   R,
  input  logic                   S,
  input  logic                   Sign,
  input  logic [1:0]             ExcIn,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MANT_W:0]  Result,
  output logic [3:0]             Flags
);

  logic                v1, v2;
  logic                adv2;
  logic                rnd_up;
  logic                s1_sign, s1_neg_e, s1_zero, s1_inexact;
  logic [1:0]          s1_exc;
  logic [EXP_W:0]      s1_norm_e;
  logic [MANT_W:0]     s1_mant_r;
  logic [EXP_W+MANT_W:0] pack_result;
  flags_t              pack_flags;

  assign adv2      = !v2 || out_ready;
  assign in_ready  = !v1 || adv2;
  assign out_valid = v2;
  // Ties (FG=1, R=S=0) round up only when the LSB is odd.
  assign rnd_up    = FG & (R | S | NormM[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exc     <= EXC_NORMAL;
      s1_neg_e   <= 1'b0;
      s1_zero    <= 1'b0;
      s1_norm_e  <= '0;
      s1_mant_r  <= '0;
      s1_inexact <= 1'b0;
      Result     <= '0;
      Flags      <= '0;
    end else begin
      if (in_ready) v1 <= in_valid;
      if (in_valid && in_ready) begin
        s1_sign    <= Sign;
        s1_exc     <= ExcIn;
        s1_neg_e   <= NegE;
        s1_zero    <= ZeroSum;
        s1_norm_e  <= NormE;
        s1_mant_r  <= {1'b0, NormM} + (MANT_W+1)'(rnd_up);
        s1_inexact <= FG | R | S;
      end
      if (adv2) v2 <= v1;
      if (v1 && adv2) begin
        Result <= pack_result;
        Flags  <= pack_flags;
      end
    end
  end

  fpaddsub_pack #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W)
  ) u_pack (
    .sign     (s1_sign),
    .exc      (s1_exc),
    .neg_e    (s1_neg_e),
    .zero_sum (s1_zero),
    .norm_e   (s1_norm_e),
    .mant_r   (s1_mant_r),
    .inexact  (s1_inexact),
    .result   (pack_result),
    .flags    (pack_flags)
  );

`ifdef FPADDSUB_STICKY_FLAGS_EN
  // A clear that lands on a transfer keeps that transfer's flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      FlagsAcc <= '0;
    end else if (flag_clr) begin
      FlagsAcc <= (v2 && out_ready) ? Flags : 4'h0;
    end else if (v2 && out_ready) begin
      FlagsAcc <= FlagsAcc | Flags;
    end
  end
`endif

endmodule
